// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic jam controller: FSM state encoding
// and default timing constants.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DETECT,
        ST_START,
        ST_HOLD,
        ST_CLEAR
    } jam_state_t;

    localparam int unsigned JAM_DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned JAM_GREEN_CYCLES_DEF    = 16;
    localparam int unsigned JAM_CLEAR_CYCLES_DEF    = 8;
    localparam int unsigned JAM_CNT_W_DEF           = 8;

endpackage

// File: rtl/jam_cycle_counter.sv
// Cycle counter shared by all jam FSM states: synchronous clear, enable,
// and a compare against a state-selected terminal value.
module jam_cycle_counter
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W = JAM_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_at_term
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/jam_ctrl_unit.sv
// Jam-mode controller: debounces the road jam sensors, issues the initial
// grant and periodic rotation pulses, and drops out after a sustained clear.
module jam_ctrl_unit
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = JAM_DEBOUNCE_CYCLES_DEF,
    parameter int unsigned GREEN_CYCLES    = JAM_GREEN_CYCLES_DEF,
    parameter int unsigned CLEAR_CYCLES    = JAM_CLEAR_CYCLES_DEF,
    parameter int unsigned CNT_W           = JAM_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jam_ctrl_en,
    input  logic             jam_sensor_0,
    input  logic             jam_sensor_1,
    input  logic             jam_sensor_2,
    input  logic             jam_sensor_3,
    output logic             jam_op_en,
    output logic             jam_start,
    output logic             jam_rotation,
    output logic             jam_active,
    output logic [CNT_W-1:0] rotation_count
);

    localparam logic [CNT_W-1:0] DEB_TERM   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_TERM = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_TERM = CNT_W'(CLEAR_CYCLES - 1);

    jam_state_t       r_state;
    logic             r_jam_op_en;
    logic             r_jam_start;
    logic             r_jam_rotation;
    logic             r_jam_active;
    logic [CNT_W-1:0] r_rotation_count;

    logic             w_any_jam;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_term;
    logic             w_at_term;

    assign w_any_jam = jam_sensor_0 | jam_sensor_1 | jam_sensor_2 | jam_sensor_3;

    // Counter restarts on every state change and on each rotation; it only
    // advances while a state is waiting out its own interval.
    always_comb begin
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        w_term    = '0;
        case (r_state)
            ST_DETECT: begin
                w_term = DEB_TERM;
                if (!w_any_jam || w_at_term) w_cnt_clr = 1'b1;
                else                         w_cnt_en  = 1'b1;
            end
            ST_HOLD: begin
                w_term = GREEN_TERM;
                if (!w_any_jam || w_at_term) w_cnt_clr = 1'b1;
                else                         w_cnt_en  = 1'b1;
            end
            ST_CLEAR: begin
                w_term = CLEAR_TERM;
                if (w_any_jam || w_at_term) w_cnt_clr = 1'b1;
                else                        w_cnt_en  = 1'b1;
            end
            default: w_cnt_clr = 1'b1;
        endcase
        if (!jam_ctrl_en) begin
            w_cnt_clr = 1'b1;
            w_cnt_en  = 1'b0;
        end
    end

    jam_cycle_counter #(
        .CNT_W(CNT_W)
    ) u_cycle_counter (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .i_term   (w_term),
        .o_at_term(w_at_term)
    );

    always_ff @(posedge clk) begin
        if (rst || !jam_ctrl_en) begin
            r_state          <= ST_IDLE;
            r_jam_op_en      <= 1'b0;
            r_jam_start      <= 1'b0;
            r_jam_rotation   <= 1'b0;
            r_jam_active     <= 1'b0;
            r_rotation_count <= '0;
        end else begin
            r_jam_start    <= 1'b0;
            r_jam_rotation <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_jam) r_state <= ST_DETECT;
                end
                ST_DETECT: begin
                    if (!w_any_jam) begin
                        r_state <= ST_IDLE;
                    end else if (w_at_term) begin
                        r_state      <= ST_START;
                        r_jam_start  <= 1'b1;
                        r_jam_op_en  <= 1'b1;
                        r_jam_active <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state          <= ST_HOLD;
                    r_rotation_count <= '0;
                end
                ST_HOLD: begin
                    if (!w_any_jam) begin
                        r_state <= ST_CLEAR;
                    end else if (w_at_term) begin
                        r_jam_rotation   <= 1'b1;
                        r_rotation_count <= r_rotation_count + CNT_W'(1);
                    end
                end
                ST_CLEAR: begin
                    if (w_any_jam) begin
                        r_state <= ST_HOLD;
                    end else if (w_at_term) begin
                        r_state      <= ST_IDLE;
                        r_jam_op_en  <= 1'b0;
                        r_jam_active <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign jam_op_en      = r_jam_op_en;
    assign jam_start      = r_jam_start;
    assign jam_rotation   = r_jam_rotation;
    assign jam_active     = r_jam_active;
    assign rotation_count = r_rotation_count;

endmodule

// File: tb/tb_jam_ctrl_unit.sv
// Self-checking bench for jam_ctrl_unit: segment table with hand-derived
// end values, per-cycle reference model scoreboard, and a minimum-timing instance.
module tb_jam_ctrl_unit;

    localparam int unsigned DEB = 4;
    localparam int unsigned GRN = 16;
    localparam int unsigned CLR = 8;

    localparam int P_IDLE  = 0;
    localparam int P_DET   = 1;
    localparam int P_START = 2;
    localparam int P_HOLD  = 3;
    localparam int P_CLR   = 4;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] sens;
    logic       op_en, start, rot, active;
    logic [7:0] rcnt;

    logic       rst1, en1;
    logic [3:0] sens1;
    logic       op_en1, start1, rot1, active1;
    logic [7:0] rcnt1;

    always #5 clk = ~clk;

    jam_ctrl_unit #(
        .DEBOUNCE_CYCLES(DEB),
        .GREEN_CYCLES   (GRN),
        .CLEAR_CYCLES   (CLR),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jam_ctrl_en   (en),
        .jam_sensor_0  (sens[0]),
        .jam_sensor_1  (sens[1]),
        .jam_sensor_2  (sens[2]),
        .jam_sensor_3  (sens[3]),
        .jam_op_en     (op_en),
        .jam_start     (start),
        .jam_rotation  (rot),
        .jam_active    (active),
        .rotation_count(rcnt)
    );

    jam_ctrl_unit #(
        .DEBOUNCE_CYCLES(1),
        .GREEN_CYCLES   (2),
        .CLEAR_CYCLES   (1),
        .CNT_W          (8)
    ) dut1 (
        .clk           (clk),
        .rst           (rst1),
        .jam_ctrl_en   (en1),
        .jam_sensor_0  (sens1[0]),
        .jam_sensor_1  (sens1[1]),
        .jam_sensor_2  (sens1[2]),
        .jam_sensor_3  (sens1[3]),
        .jam_op_en     (op_en1),
        .jam_start     (start1),
        .jam_rotation  (rot1),
        .jam_active    (active1),
        .rotation_count(rcnt1)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_step   = 0;

    // Reference model state
    int         m_ph  = P_IDLE;
    int         m_cnt = 0;
    logic       m_op = 1'b0, m_st = 1'b0, m_rt = 1'b0, m_ac = 1'b0;
    logic [7:0] m_rc = 8'd0;

    logic [11:0] sb_q[$];

    typedef struct {
        logic        r;
        logic        e;
        logic [3:0]  s;
        int unsigned n;
        logic [11:0] exp_v;
    } seg_t;

    seg_t segs[$];

    function automatic logic [11:0] ev(input logic o, input logic st, input logic rt,
                                       input logic ac, input logic [7:0] rc);
        return {o, st, rt, ac, rc};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    task automatic model_step(input logic r, input logic e, input logic aj);
        if (r || !e) begin
            m_ph = P_IDLE; m_cnt = 0;
            m_op = 1'b0; m_st = 1'b0; m_rt = 1'b0; m_ac = 1'b0; m_rc = 8'd0;
        end else begin
            m_st = 1'b0;
            m_rt = 1'b0;
            case (m_ph)
                P_IDLE:  if (aj) begin m_ph = P_DET; m_cnt = 0; end
                P_DET: begin
                    if (!aj) m_ph = P_IDLE;
                    else if (m_cnt == int'(DEB) - 1) begin m_ph = P_START; m_st = 1'b1; end
                    else m_cnt++;
                end
                P_START: begin m_ph = P_HOLD; m_cnt = 0; m_rc = 8'd0; end
                P_HOLD: begin
                    if (!aj) begin m_ph = P_CLR; m_cnt = 0; end
                    else if (m_cnt == int'(GRN) - 1) begin
                        m_rt = 1'b1; m_cnt = 0; m_rc = m_rc + 8'd1;
                    end else m_cnt++;
                end
                default: begin
                    if (aj) begin m_ph = P_HOLD; m_cnt = 0; end
                    else if (m_cnt == int'(CLR) - 1) m_ph = P_IDLE;
                    else m_cnt++;
                end
            endcase
            m_ac = (m_ph == P_START) || (m_ph == P_HOLD) || (m_ph == P_CLR);
            m_op = m_ac;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] s);
        logic [11:0] exp_v;
        logic [11:0] got_v;
        rst  = r;
        en   = e;
        sens = s;
        model_step(r, e, |s);
        sb_q.push_back({m_op, m_st, m_rt, m_ac, m_rc});
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        got_v = {op_en, start, rot, active, rcnt};
        n_step++;
        check($sformatf("cycle%0d", n_step), {20'd0, got_v}, {20'd0, exp_v});
    endtask

    task automatic seg(input logic r, input logic e, input logic [3:0] s, input int unsigned n,
                       input logic [11:0] exp_v);
        seg_t x;
        x.r = r; x.e = e; x.s = s; x.n = n; x.exp_v = exp_v;
        segs.push_back(x);
    endtask

    task automatic step1(input logic [3:0] s, input logic [11:0] exp_v, input string nm);
        rst1  = 1'b0;
        sens1 = s;
        @(posedge clk);
        #1;
        check(nm, {20'd0, op_en1, start1, rot1, active1, rcnt1}, {20'd0, exp_v});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sens = 4'b0;
        rst1 = 1'b1; en1 = 1'b1; sens1 = 4'b0;

        seg(1, 1, 4'b0000,  2, ev(0, 0, 0, 0, 0));   // reset
        seg(0, 1, 4'b0000,  3, ev(0, 0, 0, 0, 0));
        seg(0, 1, 4'b0010,  3, ev(0, 0, 0, 0, 0));   // glitch on sensor_1
        seg(0, 1, 4'b0000,  3, ev(0, 0, 0, 0, 0));
        seg(0, 1, 4'b0100,  4, ev(0, 0, 0, 0, 0));   // debounce, still DETECT
        seg(0, 1, 4'b0100,  1, ev(1, 1, 0, 1, 0));   // START after edge 5
        seg(0, 1, 4'b0100,  1, ev(1, 0, 0, 1, 0));   // HOLD entry
        seg(0, 1, 4'b0100, 15, ev(1, 0, 0, 1, 0));
        seg(0, 1, 4'b0100,  1, ev(1, 0, 1, 1, 1));   // rotation at +16
        seg(0, 1, 4'b0100, 15, ev(1, 0, 0, 1, 1));
        seg(0, 1, 4'b0100,  1, ev(1, 0, 1, 1, 2));   // rotation at +32
        seg(0, 1, 4'b0100,  8, ev(1, 0, 0, 1, 2));   // 40 cycles after entry
        seg(0, 1, 4'b0000,  5, ev(1, 0, 0, 1, 2));   // short drop
        seg(0, 1, 4'b1000,  1, ev(1, 0, 0, 1, 2));   // back to HOLD
        seg(0, 1, 4'b1000, 15, ev(1, 0, 0, 1, 2));
        seg(0, 1, 4'b1000,  1, ev(1, 0, 1, 1, 3));   // rotation 16 after recovery
        seg(0, 1, 4'b0000,  8, ev(1, 0, 0, 1, 3));   // CLEAR with counter at terminal
        seg(0, 1, 4'b0000,  1, ev(0, 0, 0, 0, 3));   // IDLE
        seg(0, 1, 4'b0001,  5, ev(1, 1, 0, 1, 3));
        seg(0, 1, 4'b0001,  1, ev(1, 0, 0, 1, 0));
        seg(0, 1, 4'b0001,  5, ev(1, 0, 0, 1, 0));
        seg(0, 0, 4'b0001,  1, ev(0, 0, 0, 0, 0));   // disable mid-HOLD
        seg(0, 0, 4'b0001,  2, ev(0, 0, 0, 0, 0));
        seg(0, 1, 4'b0001,  4, ev(0, 0, 0, 0, 0));   // full debounce again
        seg(0, 1, 4'b0001,  1, ev(1, 1, 0, 1, 0));
        seg(0, 1, 4'b0001,  1, ev(1, 0, 0, 1, 0));
        seg(0, 1, 4'b0001, 15, ev(1, 0, 0, 1, 0));   // rotation due next edge
        seg(1, 1, 4'b0001,  1, ev(0, 0, 0, 0, 0));   // reset wins over rotation
        seg(0, 1, 4'b0001,  5, ev(1, 1, 0, 1, 0));

        for (int i = 0; i < segs.size(); i++) begin
            for (int unsigned k = 0; k < segs[i].n; k++) begin
                step(segs[i].r, segs[i].e, segs[i].s);
            end
            check($sformatf("seg%0d", i), {20'd0, op_en, start, rot, active, rcnt},
                  {20'd0, segs[i].exp_v});
        end

        // Minimum intervals: debounce 1, green 2, clear 1
        step1(4'b0100, ev(0, 0, 0, 0, 0), "min_detect");
        step1(4'b0100, ev(1, 1, 0, 1, 0), "min_start");
        step1(4'b0100, ev(1, 0, 0, 1, 0), "min_hold0");
        step1(4'b0100, ev(1, 0, 0, 1, 0), "min_hold1");
        step1(4'b0100, ev(1, 0, 1, 1, 1), "min_rot1");
        step1(4'b0100, ev(1, 0, 0, 1, 1), "min_gap");
        step1(4'b0100, ev(1, 0, 1, 1, 2), "min_rot2");
        step1(4'b0000, ev(1, 0, 0, 1, 2), "min_clear");
        step1(4'b0000, ev(0, 0, 0, 0, 2), "min_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
